jt49_exp_mc: RTL and testbench

//  Multi-channel log-to-linear volume converter with per-channel anti-click ramping.

---
 rtl/jt49_exp_mc.sv | 133 +++++++++++++
 tb/tb_jt49_exp_mc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_exp_mc.sv
// Multi-channel log-to-linear volume converter with per-channel anti-click ramping.
// Round-robin scan (one channel per cen), 3-register pipeline: level/address, ROM read, output.
module jt49_exp_mc #(
    parameter int CH       = 3,
    parameter int DW       = 8,
    parameter int RAMP_DIV = 1,
    localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [1:0]    comp,
    input  logic          ramp_en,
    input  logic          wr,
    input  logic [CW-1:0] wr_ch,
    input  logic [4:0]    wr_vol,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] dout_ch,
    output logic          dout_valid
);

    // 4 curves x 32 levels, byte (c*32+v) holds round(255*10^(-(31-v)*D/600)); level 0 is silent.
    function automatic logic [1023:0] gen_rom();
        logic [1023:0] r;
        real           d;
        real           x;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            d = (c == 0) ? 43.6 : (c == 1) ? 29.1 : (c == 2) ? 21.8 : 13.4;
            for (int v = 1; v < 32; v++) begin
                x = 255.0 * (10.0 ** (-(real'(31 - v)) * d / 600.0));
                r[(c * 32 + v) * 8 +: 8] = 8'(int'(x));
            end
        end
        return r;
    endfunction

    localparam logic [1023:0] ROM = gen_rom();

    // Left-align the byte and fill the low bits by repeating it, so 0xFF becomes all-ones.
    function automatic logic [DW-1:0] expand(input logic [7:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) begin
            r[DW-1-i] = b[7-(i%8)];
        end
        return r;
    endfunction

    logic [4:0]    target_q [CH];
    logic [4:0]    cur_q    [CH];
    logic [CW-1:0] ptr_q;
    logic [7:0]    div_q;
    logic [6:0]    addr_q;
    logic [CW-1:0] ch1_q;
    logic          vld1_q;
    logic [7:0]    rom_q;
    logic [CW-1:0] ch2_q;
    logic          vld2_q;

    logic [4:0]    cur_c;
    logic [4:0]    tgt_c;
    logic [4:0]    lvl_n;
    logic          tick;
    logic          last_ch;
    logic          wr_ok;

    always_comb begin
        cur_c   = cur_q[ptr_q];
        tgt_c   = target_q[ptr_q];
        tick    = (div_q == 8'd0);
        last_ch = (ptr_q == CW'(CH - 1));
        wr_ok   = wr && (int'(wr_ch) < CH);
        lvl_n   = cur_c;
        if (!ramp_en) begin
            lvl_n = tgt_c;
        end else if (tick) begin
            if (cur_c < tgt_c) begin
                lvl_n = cur_c + 5'd1;
            end else if (cur_c > tgt_c) begin
                lvl_n = cur_c - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                target_q[i] <= 5'd0;
                cur_q[i]    <= 5'd0;
            end
            ptr_q      <= '0;
            div_q      <= 8'd0;
            addr_q     <= 7'd0;
            ch1_q      <= '0;
            vld1_q     <= 1'b0;
            rom_q      <= 8'd0;
            ch2_q      <= '0;
            vld2_q     <= 1'b0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
        end else begin
            // Stage 0 reads the old target, so a same-cycle write only affects later scans.
            if (wr_ok) begin
                target_q[wr_ch] <= wr_vol;
            end
            if (cen) begin
                cur_q[ptr_q] <= lvl_n;
                addr_q       <= {comp, lvl_n};
                ch1_q        <= ptr_q;
                if (last_ch) begin
                    ptr_q <= '0;
                    div_q <= (div_q == 8'(RAMP_DIV - 1)) ? 8'd0 : div_q + 8'd1;
                end else begin
                    ptr_q <= ptr_q + CW'(1);
                end
            end
            vld1_q <= cen;

            rom_q  <= ROM[{addr_q, 3'b000} +: 8];
            ch2_q  <= ch1_q;
            vld2_q <= vld1_q;

            dout_valid <= vld2_q;
            if (vld2_q) begin
                dout    <= expand(rom_q);
                dout_ch <= ch2_q;
            end
        end
    end

endmodule

// File: tb/tb_jt49_exp_mc.sv
// Bench for jt49_exp_mc: two instances (8-bit/div 1 and 12-bit/div 4) against a cycle model,
// plus hand-computed literal expectations.
module tb_jt49_exp_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic [1:0] comp;
    logic       ramp_en;
    logic       wr;
    logic [1:0] wr_ch;
    logic [4:0] wr_vol;

    logic [7:0]  dout_a;
    logic [1:0]  dout_ch_a;
    logic        dout_valid_a;
    logic [11:0] dout_b;
    logic [1:0]  dout_ch_b;
    logic        dout_valid_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jt49_exp_mc #(.CH(3), .DW(8), .RAMP_DIV(1)) u_a (
        .clk(clk), .rst(rst), .cen(cen), .comp(comp), .ramp_en(ramp_en), .wr(wr),
        .wr_ch(wr_ch), .wr_vol(wr_vol), .dout(dout_a), .dout_ch(dout_ch_a),
        .dout_valid(dout_valid_a)
    );

    jt49_exp_mc #(.CH(3), .DW(12), .RAMP_DIV(4)) u_b (
        .clk(clk), .rst(rst), .cen(cen), .comp(comp), .ramp_en(ramp_en), .wr(wr),
        .wr_ch(wr_ch), .wr_vol(wr_vol), .dout(dout_b), .dout_ch(dout_ch_b),
        .dout_valid(dout_valid_b)
    );

    function automatic int rom_ref(input int c, input int v);
        real d;
        if (v == 0) return 0;
        d = (c == 0) ? 43.6 : (c == 1) ? 29.1 : (c == 2) ? 21.8 : 13.4;
        return int'(255.0 * (10.0 ** (-(real'(31 - v)) * d / 600.0)));
    endfunction

    // Byte on top, then as many leading bits of the byte as still fit, repeated.
    function automatic int widen(input int b, input int dw);
        int r;
        int bits;
        int n;
        r    = b;
        bits = 8;
        while (bits < dw) begin
            n    = (dw - bits > 8) ? 8 : dw - bits;
            r    = (r << n) | (b >> (8 - n));
            bits = bits + n;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int due;
        int ch;
        int comp;
        int lvl0;
        int lvl1;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tgt[3];
    int   lvl[2][3];
    int   m_ptr;
    int   sweep;
    int   divs[2] = '{1, 4};
    int   exp_a;
    int   exp_b;

    always @(posedge clk) begin
        exp_t e;
        int   n;
        cyc++;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                tgt[i]    = 0;
                lvl[0][i] = 0;
                lvl[1][i] = 0;
            end
            m_ptr = 0;
            sweep = 0;
            q.delete();
            exp_a = 0;
            exp_b = 0;
        end else begin
            if (cen) begin
                e.due  = cyc + 2;
                e.ch   = m_ptr;
                e.comp = int'(comp);
                for (int k = 0; k < 2; k++) begin
                    n = lvl[k][m_ptr];
                    if (!ramp_en) n = tgt[m_ptr];
                    else if (sweep % divs[k] == 0) begin
                        if (n < tgt[m_ptr]) n++;
                        else if (n > tgt[m_ptr]) n--;
                    end
                    lvl[k][m_ptr] = n;
                end
                e.lvl0 = lvl[0][m_ptr];
                e.lvl1 = lvl[1][m_ptr];
                q.push_back(e);
                m_ptr = (m_ptr + 1) % 3;
                if (m_ptr == 0) sweep++;
            end
            if (wr && int'(wr_ch) < 3) tgt[wr_ch] = int'(wr_vol);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        int   ech;
        ev  = (q.size() > 0) && (q[0].due == cyc);
        ech = 0;
        if (ev) begin
            e     = q.pop_front();
            exp_a = widen(rom_ref(e.comp, e.lvl0), 8);
            exp_b = widen(rom_ref(e.comp, e.lvl1), 12);
            ech   = e.ch;
        end
        check("valid_a", 32'(dout_valid_a), 32'(ev));
        check("valid_b", 32'(dout_valid_b), 32'(ev));
        check("dout_a", 32'(dout_a), exp_a);
        check("dout_b", 32'(dout_b), exp_b);
        if (ev) begin
            check("ch_a", 32'(dout_ch_a), ech);
            check("ch_b", 32'(dout_ch_b), ech);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int ch, input int vol);
        wr     = 1'b1;
        wr_ch  = 2'(ch);
        wr_vol = 5'(vol);
        step();
        wr     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cen = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Wait for the next result of channel ch on instance d (0=a, 1=b), bounded.
    task automatic get_res(input int d, input int ch, input string name, input int exp);
        bit got;
        int val;
        got = 1'b0;
        val = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (d == 0 && dout_valid_a && int'(dout_ch_a) == ch) begin
                got = 1'b1;
                val = int'(dout_a);
            end else if (d == 1 && dout_valid_b && int'(dout_ch_b) == ch) begin
                got = 1'b1;
                val = int'(dout_b);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no result for ch%0d within 30 cycles", name, ch);
        end else begin
            check(name, val, exp);
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; comp = 2'd0; ramp_en = 1'b0;
        wr = 1'b0; wr_ch = 2'd0; wr_vol = 5'd0;
        repeat (3) step();
        rst = 1'b0;

        // first sweeps after reset are all silent
        cen = 1'b1;
        repeat (9) step();

        // jump to full scale on ch1
        do_write(1, 31);
        repeat (4) step();
        get_res(0, 1, "jump_ch1_255", 255);

        // curve changes and bubbles
        comp = 2'd2;
        repeat (6) step();
        comp = 2'd1;
        repeat (6) step();
        for (int i = 0; i < 8; i++) begin
            cen = (i % 2 == 0);
            step();
        end
        cen = 1'b1;
        comp = 2'd0;
        repeat (3) step();

        // reset mid-stream
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_valid", 32'(dout_valid_a), 0);
        check("rst_dout", 32'(dout_b), 0);
        rst = 1'b0;
        repeat (6) step();

        // ramp up to 5 then back to 2
        ramp_en = 1'b1;
        do_write(0, 5);
        repeat (30) step();
        do_write(0, 2);
        repeat (15) step();
        get_res(0, 0, "ramp_down_lvl2", 2);

        // divider: level 3 on the div-4 instance
        do_reset();
        do_write(0, 3);
        cen = 1'b1;
        repeat (42) step();
        get_res(1, 0, "div4_lvl3", 12'h020);

        // same-cycle write to the channel being scanned
        ramp_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cen = 1'b1;
        do_write(0, 15);
        get_res(0, 0, "collide_old", 0);
        get_res(0, 0, "collide_new15", 18);

        // 12-bit widening on the flattest curve, out-of-range write ignored
        do_reset();
        comp = 2'd3;
        do_write(2, 31);
        do_write(1, 1);
        do_write(3, 31);
        cen = 1'b1;
        get_res(1, 2, "w12_lvl31", 12'hFFF);
        get_res(1, 0, "w12_lvl0", 0);
        get_res(1, 1, "w12_lvl1", 12'h373);
        get_res(0, 1, "w8_c3_lvl1", 55);
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
